// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl
// 8080-style parallel read controller for the LCD panel. One transaction is
// a single command write (RS=0, WR strobe) followed by a bus turnaround and
// a programmed number of read cycles (RS=1, RD strobe). Each captured word is
// returned on rdata with a one-cycle rdata_valid pulse. The first (dummy)
// read can be suppressed with discard_first.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   start           one-cycle request, accepted only while busy=0
//   cmd             command byte, latched on accept
//   rd_count        number of read cycles incl. dummy (0 = command only)
//   discard_first   latched on accept; drops the first read word
//   busy            high from the cycle after accept until the transaction ends
//   done            one-cycle pulse in the first idle cycle after a transaction
//   rdata           last captured read word
//   rdata_valid     one-cycle pulse when rdata is updated
//   lcd_cs/rs/wr/rd panel control pins, active low
//   lcd_dout        bus drive value
//   lcd_dout_oe     bus output enable for the top-level tristate
//   lcd_din         bus sample value from the pad

module lcd_read_ctrl #(
  parameter int unsigned WR_LO = 2,
  parameter int unsigned WR_HI = 2,
  parameter int unsigned TURN  = 2,
  parameter int unsigned RD_LO = 20,
  parameter int unsigned RD_HI = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [7:0]  rd_count,
  input  logic        discard_first,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_wr,
  output logic        lcd_rd,
  output logic [15:0] lcd_dout,
  output logic        lcd_dout_oe,
  input  logic [15:0] lcd_din
);

  localparam int unsigned LP_MAX_A = (WR_LO > WR_HI) ? WR_LO : WR_HI;
  localparam int unsigned LP_MAX_B = (TURN > RD_LO) ? TURN : RD_LO;
  localparam int unsigned LP_MAX_C = (LP_MAX_A > LP_MAX_B) ? LP_MAX_A : LP_MAX_B;
  localparam int unsigned LP_MAX   = (LP_MAX_C > RD_HI) ? LP_MAX_C : RD_HI;
  localparam int unsigned PW       = $clog2(LP_MAX) + 1;

  localparam logic [PW-1:0] LP_WR_LO_LD = PW'(WR_LO - 1);
  localparam logic [PW-1:0] LP_WR_HI_LD = PW'(WR_HI - 1);
  localparam logic [PW-1:0] LP_TURN_LD  = PW'(TURN - 1);
  localparam logic [PW-1:0] LP_RD_LO_LD = PW'(RD_LO - 1);
  localparam logic [PW-1:0] LP_RD_HI_LD = PW'(RD_HI - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_LO,
    S_CMD_HI,
    S_TURN,
    S_RD_LO,
    S_RD_HI
  } state_t;

  state_t      r_state;
  logic [PW-1:0] r_phase;
  logic [7:0]  r_rd_left;
  logic [7:0]  r_cmd;
  logic        r_skip;
  logic        r_done;
  logic [15:0] r_rdata;
  logic        r_valid;
  logic        r_cs;
  logic        r_rs;
  logic        r_wr;
  logic        r_rd;
  logic [15:0] r_dout;
  logic        r_oe;

  state_t      w_state_nxt;
  logic [PW-1:0] w_phase_nxt;
  logic [7:0]  w_rd_left_nxt;
  logic [7:0]  w_cmd_nxt;
  logic        w_accept;
  logic        w_last;
  logic        w_sample;
  logic        w_done_nxt;
  logic        w_cs_nxt;
  logic        w_rs_nxt;
  logic        w_wr_nxt;
  logic        w_rd_nxt;
  logic [15:0] w_dout_nxt;
  logic        w_oe_nxt;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_phase == '0);
  // Capture happens on the edge that ends the final RD_LO cycle.
  assign w_sample = (r_state == S_RD_LO) && w_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_rd_left_nxt = r_rd_left;
    w_cmd_nxt     = r_cmd;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_CMD_LO;
          w_phase_nxt   = LP_WR_LO_LD;
          w_rd_left_nxt = rd_count;
          w_cmd_nxt     = cmd;
        end
      end
      S_CMD_LO: begin
        if (w_last) begin
          w_state_nxt = S_CMD_HI;
          w_phase_nxt = LP_WR_HI_LD;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      S_CMD_HI: begin
        if (w_last) begin
          if (r_rd_left != 8'd0) begin
            w_state_nxt = S_TURN;
            w_phase_nxt = LP_TURN_LD;
          end else begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = '0;
          end
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      S_TURN: begin
        if (w_last) begin
          w_state_nxt = S_RD_LO;
          w_phase_nxt = LP_RD_LO_LD;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      S_RD_LO: begin
        if (w_last) begin
          w_state_nxt = S_RD_HI;
          w_phase_nxt = LP_RD_HI_LD;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      S_RD_HI: begin
        if (w_last) begin
          if (r_rd_left <= 8'd1) begin
            w_state_nxt   = S_IDLE;
            w_phase_nxt   = '0;
            w_rd_left_nxt = 8'd0;
          end else begin
            w_state_nxt   = S_RD_LO;
            w_phase_nxt   = LP_RD_LO_LD;
            w_rd_left_nxt = r_rd_left - 8'd1;
          end
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
      end
    endcase

    w_done_nxt = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    // Pins are decoded from the next state and registered, so the pads
    // follow the state register exactly and stay glitch-free.
    w_cs_nxt   = 1'b1;
    w_rs_nxt   = 1'b1;
    w_wr_nxt   = 1'b1;
    w_rd_nxt   = 1'b1;
    w_dout_nxt = '0;
    w_oe_nxt   = 1'b0;
    case (w_state_nxt)
      S_CMD_LO: begin
        w_cs_nxt   = 1'b0;
        w_rs_nxt   = 1'b0;
        w_wr_nxt   = 1'b0;
        w_oe_nxt   = 1'b1;
        w_dout_nxt = {8'h00, w_cmd_nxt};
      end
      S_CMD_HI: begin
        w_cs_nxt   = 1'b0;
        w_rs_nxt   = 1'b0;
        w_oe_nxt   = 1'b1;
        w_dout_nxt = {8'h00, w_cmd_nxt};
      end
      S_TURN, S_RD_HI: begin
        w_cs_nxt = 1'b0;
      end
      S_RD_LO: begin
        w_cs_nxt = 1'b0;
        w_rd_nxt = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_rd_left <= '0;
      r_cmd     <= '0;
      r_skip    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_cs      <= 1'b1;
      r_rs      <= 1'b1;
      r_wr      <= 1'b1;
      r_rd      <= 1'b1;
      r_dout    <= '0;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_rd_left <= w_rd_left_nxt;
      r_cmd     <= w_cmd_nxt;
      r_done    <= w_done_nxt;
      r_cs      <= w_cs_nxt;
      r_rs      <= w_rs_nxt;
      r_wr      <= w_wr_nxt;
      r_rd      <= w_rd_nxt;
      r_dout    <= w_dout_nxt;
      r_oe      <= w_oe_nxt;
      r_valid   <= 1'b0;

      if (w_accept) begin
        r_skip <= discard_first;
      end

      // A skipped (dummy) read still clears the skip flag but leaves rdata alone.
      if (w_sample) begin
        r_skip <= 1'b0;
        if (!r_skip) begin
          r_rdata <= lcd_din;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign rdata_valid = r_valid;
  assign lcd_cs      = r_cs;
  assign lcd_rs      = r_rs;
  assign lcd_wr      = r_wr;
  assign lcd_rd      = r_rd;
  assign lcd_dout    = r_dout;
  assign lcd_dout_oe = r_oe;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Testbench for lcd_read_ctrl: a panel model answers RD strobes from a word
// table, a scoreboard queue holds the words expected on rdata, and a monitor
// checks the pin protocol every cycle.

module tb_lcd_read_ctrl;

  localparam int RD_LO_CYC = 20;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cmd;
  logic [7:0]  rd_count;
  logic        discard_first;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        lcd_cs;
  logic        lcd_rs;
  logic        lcd_wr;
  logic        lcd_rd;
  logic [15:0] lcd_dout;
  logic        lcd_dout_oe;
  logic [15:0] lcd_din;

  lcd_read_ctrl #(
    .WR_LO(2),
    .WR_HI(2),
    .TURN (2),
    .RD_LO(20),
    .RD_HI(5)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmd          (cmd),
    .rd_count     (rd_count),
    .discard_first(discard_first),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .lcd_cs       (lcd_cs),
    .lcd_rs       (lcd_rs),
    .lcd_wr       (lcd_wr),
    .lcd_rd       (lcd_rd),
    .lcd_dout     (lcd_dout),
    .lcd_dout_oe  (lcd_dout_oe),
    .lcd_din      (lcd_din)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared state: words/exp_cmd written by stimulus only; counters by monitor only.
  logic [15:0] words [0:7];
  logic [7:0]  exp_cmd = 8'h00;
  logic [15:0] exp_q [$];
  int e0 = 0;

  // Panel model: word k is put on the bus only in the last RD_LO cycle; a
  // junk value precedes it and 0x1234 replaces it one cycle after RD rises.
  int lo_cnt = 0;
  int hi_cnt = 0;
  int rd_idx = 0;
  initial lcd_din = 16'h0000;
  always @(negedge clk) begin
    if (!lcd_rd) begin
      lo_cnt++;
      hi_cnt = 0;
      if (lo_cnt == RD_LO_CYC && rd_idx < 8) lcd_din = words[rd_idx];
      else lcd_din = 16'hDEAD;
    end else begin
      if (lo_cnt != 0) begin
        rd_idx++;
        lo_cnt = 0;
        hi_cnt = 1;
      end else if (hi_cnt != 0) begin
        hi_cnt++;
        if (hi_cnt == 2) lcd_din = 16'h1234;
      end
    end
    if (lcd_cs) rd_idx = 0;
  end

  // Monitor
  int rd_falls = 0;
  int wr_falls = 0;
  int wr_lo_cyc = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic prev_rd = 1'b1;
  logic prev_wr = 1'b1;
  always @(negedge clk) begin
    if (!lcd_rd) chk("oe_during_rd", 32'(lcd_dout_oe), 32'(0));
    if (!lcd_cs && !lcd_dout_oe) chk("rs_when_released", 32'(lcd_rs), 32'(1));
    if (!lcd_wr) begin
      wr_lo_cyc++;
      chk("wr_phase", {13'd0, lcd_rs, lcd_cs, lcd_dout_oe, lcd_dout},
          {13'd0, 1'b0, 1'b0, 1'b1, 8'h00, exp_cmd});
    end
    if (prev_rd && !lcd_rd) rd_falls++;
    if (prev_wr && !lcd_wr) wr_falls++;
    prev_rd = lcd_rd;
    prev_wr = lcd_wr;
    if (done) done_cnt++;
    if (rdata_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) chk("valid_unexpected", 32'(1), 32'(0));
      else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] n, input logic d,
                      input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input logic [15:0] w3);
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    exp_cmd = c;
    for (int k = 0; k < int'(n); k++)
      if (!(d && k == 0)) exp_q.push_back(words[k]);
    cmd = c;
    rd_count = n;
    discard_first = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    chk("busy_cs_after_accept", {30'd0, busy, lcd_cs}, 32'b10);
  endtask

  task automatic wait_done(input int exp_d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'(0), 32'(1));
    else begin
      chk(tag, 32'(cyc - e0), 32'(exp_d));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
    end
  endtask

  int s_rd, s_wr, s_wrlo, s_val, s_done;
  int rn, rd_d;
  logic [15:0] rw [0:3];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cmd = 8'h00;
    rd_count = 8'h00;
    discard_first = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_pins", {24'd0, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_dout_oe, busy, done, rdata_valid},
        32'b1111_0000);
    chk("reset_rdata", 32'(rdata), 32'(0));
    chk("reset_dout", 32'(lcd_dout), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ID read with dummy discard; a start while busy must be ignored
    s_rd = rd_falls; s_wr = wr_falls; s_val = valid_cnt;
    send(8'hD3, 8'd4, 1'b1, 16'h0000, 16'h0000, 16'h0093, 16'h0041);
    repeat (10) @(negedge clk);
    cmd = 8'h55; rd_count = 8'd9; discard_first = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(106, "id_done");
    chk("id_rd_falls", 32'(rd_falls - s_rd), 32'(4));
    chk("id_wr_falls", 32'(wr_falls - s_wr), 32'(1));
    chk("id_valids", 32'(valid_cnt - s_val), 32'(3));
    chk("id_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("id_rdata_last", 32'(rdata), 32'h41);

    // Back-to-back: start in the done cycle
    s_rd = rd_falls; s_val = valid_cnt;
    send(8'h2E, 8'd2, 1'b0, 16'hABCD, 16'h0F0F, 16'h0000, 16'h0000);
    wait_done(56, "b2b_done");
    chk("b2b_rd_falls", 32'(rd_falls - s_rd), 32'(2));
    chk("b2b_valids", 32'(valid_cnt - s_val), 32'(2));
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("b2b_rdata_last", 32'(rdata), 32'h0F0F);

    // Command only
    repeat (3) @(negedge clk);
    s_rd = rd_falls; s_wr = wr_falls; s_wrlo = wr_lo_cyc; s_val = valid_cnt;
    send(8'h29, 8'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wait_done(4, "cmd_done");
    chk("cmd_rd_falls", 32'(rd_falls - s_rd), 32'(0));
    chk("cmd_wr_falls", 32'(wr_falls - s_wr), 32'(1));
    chk("cmd_wr_lo_cycles", 32'(wr_lo_cyc - s_wrlo), 32'(2));
    chk("cmd_valids", 32'(valid_cnt - s_val), 32'(0));

    // A few random transactions
    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rn = $urandom_range(1, 4);
      rd_d = $urandom_range(0, 1);
      for (int k = 0; k < 4; k++) rw[k] = 16'($urandom);
      s_rd = rd_falls; s_val = valid_cnt;
      send(8'($urandom), 8'(rn), rd_d[0], rw[0], rw[1], rw[2], rw[3]);
      wait_done(6 + rn * 25, "rand_done");
      chk("rand_rd_falls", 32'(rd_falls - s_rd), 32'(rn));
      chk("rand_valids", 32'(valid_cnt - s_val), 32'(rn - rd_d));
      chk("rand_queue_empty", 32'(exp_q.size()), 32'(0));
    end

    // Reset in the middle of the first RD_LO
    @(negedge clk);
    send(8'hD3, 8'd4, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    begin
      bit seen_rd;
      seen_rd = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!lcd_rd) begin
          seen_rd = 1'b1;
          break;
        end
      end
      chk("rst_reach_rd_lo", 32'(seen_rd), 32'(1));
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_pins", {27'd0, lcd_cs, lcd_wr, lcd_rd, lcd_dout_oe, busy}, 32'b11100);
    exp_q.delete();
    s_done = done_cnt; s_val = valid_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - s_done), 32'(0));
    chk("rst_no_valid", 32'(valid_cnt - s_val), 32'(0));

    // Recovery after reset
    send(8'h29, 8'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wait_done(4, "post_rst_done");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_read_ctrl.md
# lcd_read_ctrl

8080-style parallel read controller for the LCD panel: it issues one command write (RS=0, WR strobe), releases the data bus, then performs a programmed number of read cycles (RS=1, RD strobe) and returns the sampled words. It is the read-direction counterpart of the existing write path. It is used for panel ID readback (e.g. 0xD3) and GRAM readback (0x2E). It sits beside the write controllers, and top-level muxing hands it the CS/RS/WR/RD/DATA pins while it is busy.

## Interface
- WR_LO, 2: cycles WR is held low during the command write.
- WR_HI, 2: cycles WR is held high after the command, with data still driven.
- TURN, 2: bus-turnaround cycles (oe=0, RS=1, CS low) before the first RD.
- RD_LO, 20: cycles RD is held low per read (400 ns at 50 MHz).
- RD_HI, 5: cycles RD is held high per read.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cmd  in  8  command byte, latched on accept.
- rd_count  in  8  number of read cycles, including the dummy read; 0 means command only.
- discard_first  in  1  latched on accept; suppresses output of the first read (dummy).
- busy  out  1  high from the cycle after accept until the transaction ends.
- done  out  1  one-cycle pulse in the first idle cycle after a transaction.
- rdata  out  16  last captured read word.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- lcd_cs, lcd_rs, lcd_wr, lcd_rd  out  1 each  panel control pins, active low.
- lcd_dout  out  16  bus drive value.
- lcd_dout_oe  out  1  bus output enable; the top-level tristate uses it.
- lcd_din  in  16  bus sample value from the pad.

## Operation
- Reset values: busy=0, done=0, rdata=0, rdata_valid=0, lcd_cs=1, lcd_rs=1, lcd_wr=1, lcd_rd=1, lcd_dout=0, lcd_dout_oe=0. All internal counters and state are set to IDLE.
- States: IDLE -> CMD_LO -> CMD_HI -> TURN -> RD_LO <-> RD_HI -> IDLE.
- IDLE
  - start=1 latches cmd, rd_count and discard_first, then enters CMD_LO.
  - start is ignored while busy.
- CMD_LO, WR_LO cycles: cs=0, rs=0, wr=0, oe=1, dout={8'h00,cmd}.
- CMD_HI, WR_HI cycles: wr=1, all else held.
- Exit from CMD_HI: to TURN if rd_count>0, else directly to IDLE.
- TURN, TURN cycles: oe=0, rs=1, cs=0, dout=0.
- RD_LO, RD_LO cycles: rd=0.
  - On the clock edge ending the last RD_LO cycle, rdata<=lcd_din and rd returns to 1.
- Output of each read:
  - rdata_valid pulses in the following cycle, except for the first read when discard_first=1.
  - A discarded read leaves rdata unchanged.
- RD_HI, RD_HI cycles: rd=1.
  - After the last read's RD_HI, cs=1 and the block enters IDLE.
- In the first IDLE cycle after any transaction: done=1 and busy=0, so a new start is accepted in that same cycle.
- Phase counter: width $clog2 of the largest parameter, plus 1. Read counter: 8 bits, counts down, no wrap.
- Parameter values below 1 are illegal and are not checked.

## Timing
- Accept edge = E0. busy=1 and cs=0 from E0+1.
- Duration of a transaction: D = WR_LO+WR_HI+TURN·[N>0]+N·(RD_LO+RD_HI) cycles, for N = rd_count. done is high in cycle E0+D+1.
- Defaults: N=4 gives D=106; N=0 gives D=4.
- Read k (k=0..N-1):
  - RD falls at E0+1+6+k·25.
  - lcd_din is sampled at E0+6+k·25+20.
  - rdata_valid is high the cycle after sampling.
- Simultaneous events:
  - start in the done cycle is accepted; done still pulses and busy rises the next cycle.
  - start while busy is dropped with no side effects.
- Reset mid-transaction: all pins return to idle values immediately (asynchronous). No done pulse follows, and a partially read word is not output.

## Test plan
- Reset: assert rst mid-RD_LO → lcd_cs, lcd_rd and lcd_wr are 1 and lcd_dout_oe=0 within the same cycle; busy=0. After release, no done and no rdata_valid appear.
- ID read: cmd=0xD3, rd_count=4, discard_first=1; the panel model drives 0x0000, 0x0000, 0x0093, 0x0041.
  - Expect three rdata_valid pulses with values 0x0000, 0x0093, 0x0041.
  - Expect done at E0+107 and exactly 4 RD falling edges and 1 WR falling edge.
- Command only: cmd=0x29, rd_count=0 → WR low for 2 cycles with lcd_dout=0x0029 and rs=0; lcd_rd never toggles; done at E0+5.
- Sample point: the panel model changes lcd_din to 0xABCD in the final RD_LO cycle and to 0x1234 one cycle after RD rises → rdata=0xABCD.
- Turnaround: check lcd_dout_oe=0 on every cycle where lcd_rd=0, and that rs=1 whenever oe=0 while cs=0.
- Back-to-back: pulse start during busy → ignored. Pulse start in the done cycle (cmd=0x2E, rd_count=2, discard_first=0) → accepted; two valid pulses follow.
